// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one RAM port between instruction fetch and load/store
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate the winner of simultaneous requests.

module mem_port_arbiter #(
    parameter int MEM_LAT   = 2,
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        stall_if,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic        owner_d;
    logic [31:0] lat_addr, lat_wdata;
    logic        lat_rw;
    logic [1:0]  lat_size;
    logic        err_q;
    logic        gnt_if_q, gnt_d_q;

    logic        any_req, sel_d, tie_data;
    logic [31:0] win_addr, win_wdata;
    logic        win_rw, win_err;
    logic [1:0]  win_size;
    logic        last_beat, done_cyc;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == 2'b11) || (size == 2'b10 && a != 2'b00) || (size == 2'b01 && a[0]);
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_ptr;

    // Pointer 0 favours data; it flips only when both requesters compete.
    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= 1'b0;
        else if (state == IDLE && if_req && d_req)
            rr_ptr <= ~rr_ptr;
    end

    assign tie_data = ~rr_ptr;
`else
    assign tie_data = DATA_PRIO;
`endif

    always_comb begin
        any_req   = if_req || d_req;
        sel_d     = d_req && (!if_req || tie_data);
        win_addr  = sel_d ? d_addr : if_addr;
        win_rw    = sel_d ? d_rw : 1'b0;
        win_size  = sel_d ? d_size : 2'b10;
        win_wdata = sel_d ? d_wdata : 32'h0;
        win_err   = misaligned(win_size, win_addr[1:0]);
    end

    assign last_beat = (state == ACCESS) && (cnt == LAST_CNT);
    // A misaligned grant enters DONE in its grant cycle; done waits one cycle so it follows gnt.
    assign done_cyc  = (state == DONE) && !gnt_if_q && !gnt_d_q;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = win_err ? DONE : ACCESS;
            ACCESS:  if (last_beat) state_next = DONE;
            DONE:    if (done_cyc) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 4'd0;
            owner_d   <= 1'b0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_rw    <= 1'b0;
            lat_size  <= 2'b00;
            err_q     <= 1'b0;
            gnt_if_q  <= 1'b0;
            gnt_d_q   <= 1'b0;
            if_rdata  <= 32'h0;
            d_rdata   <= 32'h0;
        end else begin
            gnt_if_q <= 1'b0;
            gnt_d_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_d   <= sel_d;
                        lat_addr  <= win_addr;
                        lat_wdata <= win_wdata;
                        lat_rw    <= win_rw;
                        lat_size  <= win_size;
                        err_q     <= win_err;
                        cnt       <= 4'd0;
                        gnt_d_q   <= sel_d;
                        gnt_if_q  <= ~sel_d;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (last_beat && !lat_rw) begin
                        if (owner_d)
                            d_rdata <= mem_rdata;
                        else
                            if_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_size  = 2'b00;
        if_done   = 1'b0;
        if_err    = 1'b0;
        d_done    = 1'b0;
        d_err     = 1'b0;
        if (state == ACCESS) begin
            mem_en    = 1'b1;
            mem_rw    = lat_rw;
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            mem_size  = lat_size;
        end
        if (done_cyc) begin
            if (owner_d) begin
                d_done = 1'b1;
                d_err  = err_q;
            end else begin
                if_done = 1'b1;
                if_err  = err_q;
            end
        end
    end

    assign if_gnt   = gnt_if_q;
    assign d_gnt    = gnt_d_q;
    assign stall_if = if_req && !if_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a 256x8 RAM model

module tb_mem_port_arbiter;

    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_gnt, if_done, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_rw = 1'b0;
    logic [1:0]  d_size = 2'b00;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic        d_gnt, d_done, d_err;
    logic [31:0] d_rdata;
    logic        stall_if;
    logic        mem_en, mem_rw;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .DATA_PRIO(1'b1)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .stall_if(stall_if),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM behaves as a big-endian byte array: the lowest address holds the most significant byte.
    logic [7:0] tb_ram [256];
    logic [7:0] ra;
    always_comb begin
        ra = mem_addr[7:0];
        case (mem_size)
            2'b00:   mem_rdata = {24'h0, tb_ram[ra]};
            2'b01:   mem_rdata = {16'h0, tb_ram[ra], tb_ram[ra + 8'd1]};
            default: mem_rdata = {tb_ram[ra], tb_ram[ra + 8'd1], tb_ram[ra + 8'd2], tb_ram[ra + 8'd3]};
        endcase
    end

    task automatic ram_write(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b00: tb_ram[a] = wd[7:0];
            2'b01: begin tb_ram[a] = wd[15:8]; tb_ram[a + 8'd1] = wd[7:0]; end
            default: begin
                tb_ram[a] = wd[31:24]; tb_ram[a + 8'd1] = wd[23:16];
                tb_ram[a + 8'd2] = wd[15:8]; tb_ram[a + 8'd3] = wd[7:0];
            end
        endcase
    endtask

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Results of the last run_pair call.
    int          r_if_gnt, r_if_gnt_n, r_if_done, r_if_men, r_stall;
    int          r_d_gnt, r_d_gnt_n, r_d_done, r_d_men;
    bit          r_if_err, r_d_err, r_timeout;
    logic [31:0] r_if_rdata, r_d_rdata;
    int          r_bad;

    // Raise one or both requests in the same cycle, hold each until its done, record what happened.
    task automatic run_pair(input bit fe, input logic [31:0] fa, input bit de, input bit drw,
                            input logic [1:0] dsz, input logic [31:0] da, input logic [31:0] dw);
        bit f_act, d_act;
        int owner;
        r_if_gnt = -1; r_if_gnt_n = 0; r_if_done = -1; r_if_men = 0; r_stall = 0;
        r_d_gnt = -1; r_d_gnt_n = 0; r_d_done = -1; r_d_men = 0; r_bad = 0;
        r_if_err = 1'b0; r_d_err = 1'b0; r_if_rdata = 32'h0; r_d_rdata = 32'h0;
        @(negedge clk);
        if_req = fe; if_addr = fa;
        d_req = de; d_rw = drw; d_size = dsz; d_addr = da; d_wdata = dw;
        f_act = fe; d_act = de; owner = 0;
        for (int c = 0; c < 40 && (f_act || d_act); c++) begin
            #1;
            if (if_gnt) begin r_if_gnt = c; r_if_gnt_n++; owner = 1; end
            if (d_gnt)  begin r_d_gnt = c;  r_d_gnt_n++;  owner = 2; end
            if (mem_en) begin
                if (owner == 1) begin
                    r_if_men++;
                    if (mem_addr != fa || mem_rw || mem_size != 2'b10) r_bad++;
                end else if (owner == 2) begin
                    r_d_men++;
                    if (mem_addr != da || mem_rw != drw || mem_size != dsz || (drw && mem_wdata != dw))
                        r_bad++;
                end else begin
                    r_bad++;
                end
                if (mem_rw) ram_write(mem_addr[7:0], mem_size, mem_wdata);
            end else if (mem_addr != 0 || mem_rw || mem_wdata != 0 || mem_size != 0) begin
                r_bad++;
            end
            if (stall_if) r_stall++;
            if (if_done) begin
                r_if_done = c; r_if_err = if_err; r_if_rdata = if_rdata;
                if_req = 1'b0; f_act = 1'b0; owner = 0;
            end
            if (d_done) begin
                r_d_done = c; r_d_err = d_err; r_d_rdata = d_rdata;
                d_req = 1'b0; d_act = 1'b0; owner = 0;
            end
            if (f_act || d_act) @(negedge clk);
        end
        r_timeout = f_act || d_act;
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic check_txn(input string tag, input bit is_d, input bit e_err,
                             input logic [31:0] e_rd, input int e_gnt, input int e_done);
        int e_men;
        e_men = e_err ? 0 : MEM_LAT;
        check({tag, " timeout"}, 64'(r_timeout), 64'd0);
        check({tag, " mem_bus"}, 64'(r_bad), 64'd0);
        if (is_d) begin
            check({tag, " d_gnt_cycle"}, 64'(r_d_gnt), 64'(e_gnt));
            check({tag, " d_gnt_count"}, 64'(r_d_gnt_n), 64'd1);
            check({tag, " d_done_cycle"}, 64'(r_d_done), 64'(e_done));
            check({tag, " d_err"}, 64'(r_d_err), 64'(e_err));
            check({tag, " d_rdata"}, 64'(r_d_rdata), 64'(e_rd));
            check({tag, " d_mem_en_cycles"}, 64'(r_d_men), 64'(e_men));
        end else begin
            check({tag, " if_gnt_cycle"}, 64'(r_if_gnt), 64'(e_gnt));
            check({tag, " if_gnt_count"}, 64'(r_if_gnt_n), 64'd1);
            check({tag, " if_done_cycle"}, 64'(r_if_done), 64'(e_done));
            check({tag, " if_err"}, 64'(r_if_err), 64'(e_err));
            check({tag, " if_rdata"}, 64'(r_if_rdata), 64'(e_rd));
            check({tag, " if_mem_en_cycles"}, 64'(r_if_men), 64'(e_men));
            check({tag, " stall_cycles"}, 64'(r_stall), 64'(e_done));
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ctl"}, 64'({if_gnt, if_done, if_err, d_gnt, d_done, d_err, stall_if,
                                  mem_en, mem_rw, mem_size}), 64'd0);
        check({tag, " if_rdata"}, 64'(if_rdata), 64'd0);
        check({tag, " d_rdata"}, 64'(d_rdata), 64'd0);
        check({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
    endtask

    // Reference model: byte array, alignment rules, and the last value each requester was handed.
    logic [7:0]  ref_mem [256];
    logic [31:0] m_if_rdata, m_d_rdata;
    bit          m_ptr;

    task automatic model_acc(input bit is_d, input bit rw, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd,
                             output bit err, output logic [31:0] rd);
        int b;
        int n;
        logic [31:0] v;
        b = int'(a[7:0]);
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        err = (sz == 2'b11) || (a % n != 0);
        if (!err) begin
            if (rw) begin
                for (int k = 0; k < n; k++) ref_mem[(b + k) % 256] = 8'(wd >> (8 * (n - 1 - k)));
            end else begin
                v = 32'h0;
                for (int k = 0; k < n; k++) v = (v << 8) | 32'(ref_mem[(b + k) % 256]);
                if (is_d) m_d_rdata = v; else m_if_rdata = v;
            end
        end
        rd = is_d ? m_d_rdata : m_if_rdata;
    endtask

    typedef struct {
        bit          is_d;
        bit          rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          exp_done;
    } vec_t;

    vec_t tbl [12];

    initial begin
        bit          ferr, derr, dfirst;
        logic [31:0] frd, drd;
        int          t1, t2;
        bit          order [$];
        bit          exp_order [4];
        int          n_done, n_gnt, n_men;

        for (int i = 0; i < 256; i++) tb_ram[i] = 8'h00;
        tb_ram[8'h10] = 8'hDE; tb_ram[8'h11] = 8'hAD; tb_ram[8'h12] = 8'hBE; tb_ram[8'h13] = 8'hEF;

        tbl[0]  = '{0, 0, 2'b10, 32'h10, 32'h0,        0, 32'hDEADBEEF, 3};
        tbl[1]  = '{1, 1, 2'b01, 32'h40, 32'h0000ABCD, 0, 32'h0,        3};
        tbl[2]  = '{1, 0, 2'b01, 32'h40, 32'h0,        0, 32'h0000ABCD, 3};
        tbl[3]  = '{1, 0, 2'b10, 32'h22, 32'h0,        1, 32'h0000ABCD, 2};
        tbl[4]  = '{1, 0, 2'b11, 32'h20, 32'h0,        1, 32'h0000ABCD, 2};
        tbl[5]  = '{1, 1, 2'b00, 32'h51, 32'h0000005A, 0, 32'h0000ABCD, 3};
        tbl[6]  = '{1, 0, 2'b00, 32'h51, 32'h0,        0, 32'h0000005A, 3};
        tbl[7]  = '{0, 0, 2'b10, 32'h12, 32'h0,        1, 32'hDEADBEEF, 2};
        tbl[8]  = '{1, 1, 2'b10, 32'h60, 32'h12345678, 0, 32'h0000005A, 3};
        tbl[9]  = '{1, 0, 2'b10, 32'h60, 32'h0,        0, 32'h12345678, 3};
        tbl[10] = '{1, 0, 2'b01, 32'h61, 32'h0,        1, 32'h12345678, 2};
        tbl[11] = '{0, 0, 2'b10, 32'h60, 32'h0,        0, 32'h12345678, 3};

        reset_dut();
        #1;
        check_all_zero("reset");

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].is_d)
                run_pair(1'b0, 32'h0, 1'b1, tbl[i].rw, tbl[i].size, tbl[i].addr, tbl[i].wdata);
            else
                run_pair(1'b1, tbl[i].addr, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
            check_txn($sformatf("tbl%0d", i), tbl[i].is_d, tbl[i].exp_err, tbl[i].exp_rdata,
                      1, tbl[i].exp_done);
        end

        // Collision: data wins, fetch follows after one bubble.
        run_pair(1'b1, 32'h10, 1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
        check_txn("collide_d", 1'b1, 1'b0, 32'h0, 1, 3);
        check_txn("collide_f", 1'b0, 1'b0, 32'hDEADBEEF, 5, 7);

        // Both requesters held high across four accesses.
        reset_dut();
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_rw = 1'b0; d_size = 2'b10; d_addr = 32'h20;
        n_done = 0;
        for (int c = 0; c < 60 && n_done < 4; c++) begin
            #1;
            if (d_gnt) order.push_back(1'b1);
            if (if_gnt) order.push_back(1'b0);
            if (d_done || if_done) n_done++;
            if (n_done < 4) @(negedge clk);
        end
        if_req = 1'b0; d_req = 1'b0;
        check("hold_done_count", 64'(n_done), 64'd4);
        check("hold_gnt_count", 64'(order.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("hold_winner%0d", k), 64'(k < order.size() ? order[k] : 1'bx),
                  64'(exp_order[k]));

        // Reset during the first mem_en cycle aborts the access.
        @(negedge clk);
        d_req = 1'b1; d_rw = 1'b0; d_size = 2'b10; d_addr = 32'h10;
        n_men = 0;
        for (int c = 0; c < 10 && n_men == 0; c++) begin
            #1;
            if (mem_en) n_men = 1;
            else @(negedge clk);
        end
        check("abort_saw_mem_en", 64'(n_men), 64'd1);
        reset = 1'b1; d_req = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("abort");
        reset = 1'b0;
        n_gnt = 0; n_done = 0; n_men = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            n_gnt  += int'(d_gnt) + int'(if_gnt);
            n_done += int'(d_done) + int'(if_done);
            n_men  += int'(mem_en);
        end
        check("abort_no_gnt", 64'(n_gnt), 64'd0);
        check("abort_no_done", 64'(n_done), 64'd0);
        check("abort_no_mem_en", 64'(n_men), 64'd0);

        // Randomized traffic against the reference model.
        reset_dut();
        for (int i = 0; i < 256; i++) begin
            tb_ram[i] = 8'($urandom);
            ref_mem[i] = tb_ram[i];
        end
        m_if_rdata = 32'h0; m_d_rdata = 32'h0; m_ptr = 1'b0;
        for (int it = 0; it < 80; it++) begin
            int mode, szr;
            bit fe, de, drw;
            logic [1:0] dsz;
            logic [31:0] fa, da, dw;
            mode = $urandom_range(0, 2);
            fe = (mode != 1); de = (mode != 0);
            fa = 32'($urandom_range(0, 63)) * 4 + (($urandom_range(0, 5) == 0) ? 32'd2 : 32'd0);
            szr = $urandom_range(0, 9);
            dsz = (szr == 9) ? 2'b11 : 2'(szr % 3);
            da = 32'($urandom_range(0, 252));
            if ($urandom_range(0, 3) != 0) da = da & ~32'd3;
            dw = $urandom;
            drw = 1'($urandom_range(0, 1));
`ifdef ARB_ROUND_ROBIN_EN
            dfirst = !m_ptr;
            if (fe && de) m_ptr = !m_ptr;
`else
            dfirst = 1'b1;
`endif
            run_pair(fe, fa, de, drw, dsz, da, dw);
            if (fe && de) begin
                if (dfirst) begin
                    model_acc(1'b1, drw, dsz, da, dw, derr, drd);
                    model_acc(1'b0, 1'b0, 2'b10, fa, 32'h0, ferr, frd);
                    t1 = 1 + (derr ? 1 : MEM_LAT);
                    t2 = t1 + 2;
                    check_txn($sformatf("rnd%0d_d", it), 1'b1, derr, drd, 1, t1);
                    check_txn($sformatf("rnd%0d_f", it), 1'b0, ferr, frd, t2, t2 + (ferr ? 1 : MEM_LAT));
                end else begin
                    model_acc(1'b0, 1'b0, 2'b10, fa, 32'h0, ferr, frd);
                    model_acc(1'b1, drw, dsz, da, dw, derr, drd);
                    t1 = 1 + (ferr ? 1 : MEM_LAT);
                    t2 = t1 + 2;
                    check_txn($sformatf("rnd%0d_f", it), 1'b0, ferr, frd, 1, t1);
                    check_txn($sformatf("rnd%0d_d", it), 1'b1, derr, drd, t2, t2 + (derr ? 1 : MEM_LAT));
                end
            end else if (de) begin
                model_acc(1'b1, drw, dsz, da, dw, derr, drd);
                check_txn($sformatf("rnd%0d_d", it), 1'b1, derr, drd, 1, 1 + (derr ? 1 : MEM_LAT));
                check($sformatf("rnd%0d_stall", it), 64'(r_stall), 64'd0);
            end else begin
                model_acc(1'b0, 1'b0, 2'b10, fa, 32'h0, ferr, frd);
                check_txn($sformatf("rnd%0d_f", it), 1'b0, ferr, frd, 1, 1 + (ferr ? 1 : MEM_LAT));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
